// File: rtl/demux_gather_4_pkg.sv
// Shared definitions for the 4-lane time-multiplexed bus stages.
// Lane count, lane select type and one-hot lane decode.
package mux_demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] lane_sel_t;

    function automatic logic [3:0] onehot4(lane_sel_t sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_gather_4_if.sv
// Handshake bundle between the shared-bus side and the gathered-frame side.
// The master drives words in and takes frames out; the slave is the gatherer.
interface demux_gather_4_if #(parameter int WIDTH = 2);
    import mux_demux_pkg::*;

    logic [WIDTH-1:0]             in_data;
    lane_sel_t                    in_sel;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES-1:0][WIDTH-1:0]  outp;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0]             fill_mask;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, outp, out_valid, fill_mask
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, outp, out_valid, fill_mask
    );

endinterface

// File: rtl/demux_gather_4_lane_slot.sv
// One lane of the gather buffer: a data word and a bit saying it is filled.
// A write wins over a clear so a drain edge can start the next frame.
module lane_slot #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_o,
    output logic             fill_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;

    always_comb begin
        data_d = data_q;
        fill_d = fill_q;
        if (wr_en) begin
            data_d = d;
            fill_d = 1'b1;
        end else if (clr) begin
            fill_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            fill_q <= 1'b0;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
        end
    end

    assign q_o    = data_q;
    assign fill_o = fill_q;

endmodule

// File: rtl/demux_gather_4.sv
// Gathers tagged words from the shared bus into 4-lane frames.
// A frame is offered once every lane holds a word; draining frees all lanes.
module demux_gather_4
    import mux_demux_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input logic              clk,
    input logic              rst,
    demux_gather_4_if.slave  bus
);

    logic [LANES-1:0][WIDTH-1:0] laneData;
    logic [LANES-1:0]            fill;
    logic [LANES-1:0]            wrEn;
    logic                        frameValid;
    logic                        drain;
    logic                        inReady;
    logic                        accept;

    assign frameValid = &fill;
    assign drain      = frameValid && bus.out_ready;
    // A filled lane only accepts when the frame holding it leaves on this edge.
    assign inReady    = !rst && (!fill[bus.in_sel] || drain);
    assign accept     = bus.in_valid && inReady;
    assign wrEn       = accept ? onehot4(bus.in_sel) : '0;

    for (genvar i = 0; i < LANES; i++) begin : g_slot
        lane_slot #(.WIDTH(WIDTH)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wrEn[i]),
            .clr    (drain),
            .d      (bus.in_data),
            .q_o    (laneData[i]),
            .fill_o (fill[i])
        );
    end

    assign bus.in_ready  = inReady;
    assign bus.outp      = laneData;
    assign bus.out_valid = frameValid;
    assign bus.fill_mask = fill;

endmodule

// File: tb/tb_demux_gather_4.sv
// Self-checking bench for demux_gather_4 with WIDTH=8: directed frames with
// literal expectations, then randomized traffic against a lane-buffer model.
module tb_demux_gather_4;

    localparam int W = 8;

    logic clk;
    logic rst;

    demux_gather_4_if #(.WIDTH(W)) bus ();

    demux_gather_4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int assertCount = 0;
    int failCount   = 0;

    // Reference view: what each lane holds and which lanes are filled.
    logic [W-1:0] mLane [4];
    logic [3:0]   mFill;
    logic         mAcc;
    bit           checkEn;

    initial begin
        mFill = 4'h0;
        for (int j = 0; j < 4; j++) mLane[j] = '0;
    end

    function automatic logic expReady();
        return !rst && (!mFill[bus.in_sel] || ((mFill == 4'hF) && bus.out_ready));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model advances on every rising edge from the inputs held over the cycle.
    always @(posedge clk) begin
        if (rst) begin
            mFill = 4'h0;
            for (int j = 0; j < 4; j++) mLane[j] = '0;
        end else begin
            mAcc = bus.in_valid && expReady();
            if ((mFill == 4'hF) && bus.out_ready) mFill = 4'h0;
            if (mAcc) begin
                mLane[bus.in_sel] = bus.in_data;
                mFill[bus.in_sel] = 1'b1;
            end
        end
    end

    // Every falling edge the DUT must agree with the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_fill_mask", {28'h0, bus.fill_mask}, {28'h0, mFill});
            checkOutput("cyc_out_valid", {31'h0, bus.out_valid}, {31'h0, (mFill == 4'hF)});
            checkOutput("cyc_in_ready", {31'h0, bus.in_ready}, {31'h0, expReady()});
            checkOutput("cyc_outp", bus.outp, {mLane[3], mLane[2], mLane[1], mLane[0]});
        end
    end

    // Drive one cycle of inputs and return just after the edge that samples them.
    task automatic applyStimulus(input logic valid, input logic [1:0] sel,
                                 input logic [W-1:0] data, input logic ready);
        bus.in_valid  = valid;
        bus.in_sel    = sel;
        bus.in_data   = data;
        bus.out_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic probeReady(input string name, input logic [1:0] sel,
                              input logic [W-1:0] data, input logic ready,
                              input logic expected);
        bus.in_valid  = 1'b1;
        bus.in_sel    = sel;
        bus.in_data   = data;
        bus.out_ready = ready;
        #1;
        checkOutput(name, {31'h0, bus.in_ready}, {31'h0, expected});
    endtask

    initial begin
        rst           = 1'b1;
        checkEn       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkEn = 1'b1;
        checkOutput("rst_fill", {28'h0, bus.fill_mask}, 32'h0);
        checkOutput("rst_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("rst_outp", bus.outp, 32'h0);
        probeReady("rst_in_ready", 2'd0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h00, 1'b1);
        rst = 1'b0;

        // In-order frame
        applyStimulus(1'b1, 2'd0, 8'h11, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'h22, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'h33, 1'b1);
        checkOutput("t1_not_valid_yet", {31'h0, bus.out_valid}, 32'h0);
        applyStimulus(1'b1, 2'd3, 8'h44, 1'b1);
        checkOutput("t1_valid", {31'h0, bus.out_valid}, 32'h1);
        checkOutput("t1_outp", bus.outp, 32'h44332211);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        checkOutput("t1_drained", {28'h0, bus.fill_mask}, 32'h0);

        // Out-of-order frame
        applyStimulus(1'b1, 2'd2, 8'hA2, 1'b1);
        checkOutput("t2_mask0", {28'h0, bus.fill_mask}, 32'h4);
        applyStimulus(1'b1, 2'd0, 8'hA0, 1'b1);
        checkOutput("t2_mask1", {28'h0, bus.fill_mask}, 32'h5);
        applyStimulus(1'b1, 2'd3, 8'hA3, 1'b1);
        checkOutput("t2_mask2", {28'h0, bus.fill_mask}, 32'hD);
        applyStimulus(1'b1, 2'd1, 8'hA1, 1'b1);
        checkOutput("t2_mask3", {28'h0, bus.fill_mask}, 32'hF);
        checkOutput("t2_outp", bus.outp, 32'hA3A2A1A0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);

        // Duplicate lane stalls until the frame drains
        applyStimulus(1'b1, 2'd1, 8'h55, 1'b0);
        probeReady("t3_dup_stall", 2'd1, 8'h66, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 8'h66, 1'b0);
        checkOutput("t3_lane1_kept", {24'h0, bus.outp[1]}, 32'h55);
        checkOutput("t3_mask", {28'h0, bus.fill_mask}, 32'h2);
        applyStimulus(1'b1, 2'd0, 8'h50, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'h52, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h53, 1'b0);
        checkOutput("t3_outp", bus.outp, 32'h53525550);
        applyStimulus(1'b1, 2'd1, 8'h66, 1'b1);
        checkOutput("t3_next_mask", {28'h0, bus.fill_mask}, 32'h2);
        checkOutput("t3_next_lane1", {24'h0, bus.outp[1]}, 32'h66);

        // Backpressure, then drain overlapped with the next frame's first word
        applyStimulus(1'b1, 2'd0, 8'h90, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'h92, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h93, 1'b0);
        for (int c = 0; c < 5; c++) begin
            probeReady("t4_stall_ready", 2'd3, 8'h99, 1'b0, 1'b0);
            applyStimulus(1'b1, 2'd3, 8'h99, 1'b0);
            checkOutput("t4_hold_valid", {31'h0, bus.out_valid}, 32'h1);
            checkOutput("t4_hold_outp", bus.outp, 32'h93926690);
        end
        probeReady("t4_overlap_ready", 2'd3, 8'h99, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h99, 1'b1);
        checkOutput("t4_mask", {28'h0, bus.fill_mask}, 32'h8);
        checkOutput("t4_lane3", {24'h0, bus.outp[3]}, 32'h99);

        // Reset discards a partial frame
        applyStimulus(1'b1, 2'd0, 8'hB0, 1'b0);
        applyStimulus(1'b1, 2'd1, 8'hB1, 1'b0);
        checkOutput("t5_partial", {28'h0, bus.fill_mask}, 32'hB);
        rst = 1'b1;
        probeReady("t5_rst_ready", 2'd2, 8'hB2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t5_fill", {28'h0, bus.fill_mask}, 32'h0);
        checkOutput("t5_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("t5_outp", bus.outp, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 2'd0, 8'hC0, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'hC1, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'hC2, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'hC3, 1'b1);
        checkOutput("t5_frame", bus.outp, 32'hC3C2C1C0);

        // Back-to-back streaming of four frames
        for (int i = 0; i < 16; i++) begin
            probeReady("t6_ready", 2'(i % 4), 8'(i), 1'b1, 1'b1);
            applyStimulus(1'b1, 2'(i % 4), 8'(i), 1'b1);
            if (i % 4 == 3) begin
                checkOutput("t6_valid", {31'h0, bus.out_valid}, 32'h1);
                checkOutput("t6_frame", bus.outp,
                            {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
            end
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
